// File: rtl/twpm_ram_pkg.sv
// Shared types and constants for the TPM RAM sequencer/arbiter.
// Owner encoding, FSM state enum and the default data-provider reject byte.
package twpm_ram_pkg;

    localparam logic OWNER_DP  = 1'b0;
    localparam logic OWNER_CPU = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [7:0] DP_REJECT_DATA_DEFAULT = 8'hFF;

endpackage

// File: rtl/tpm_ram_lane_steer.sv
// Byte-lane steering for the byte-wide data-provider side of the TPM RAM.
// Ports: wr_lane/wr_byte -> wen/wdata (write), rd_lane/rd_word -> rd_byte (read).
module tpm_ram_lane_steer (
    input  logic [1:0]  wr_lane,
    input  logic [7:0]  wr_byte,
    input  logic [1:0]  rd_lane,
    input  logic [31:0] rd_word,
    output logic [3:0]  wen,
    output logic [31:0] wdata,
    output logic [7:0]  rd_byte
);

    always_comb begin
        wen     = 4'b0001 << wr_lane;
        wdata   = {24'd0, wr_byte} << {wr_lane, 3'b000};
        rd_byte = rd_word[{rd_lane, 3'b000} +: 8];
    end

endmodule

// File: rtl/tpm_ram_arbiter.sv
// Sequencer/arbiter for the shared 512x32 TPM RAM (data provider vs Wishbone CPU).
// Ports: clk_i/rst_i, exec_i ownership, dp_* byte port, wb_* word port,
//        ram_* registered RAM interface, owner_o/busy_o status.
module tpm_ram_arbiter
    import twpm_ram_pkg::*;
#(
    parameter int         ADDR_WIDTH     = 11,
    parameter logic [7:0] DP_REJECT_DATA = DP_REJECT_DATA_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  exec_i,
    input  logic                  dp_req_i,
    input  logic                  dp_we_i,
    input  logic [ADDR_WIDTH-1:0] dp_addr_i,
    input  logic [7:0]            dp_data_i,
    output logic [7:0]            dp_data_o,
    output logic                  dp_ack_o,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [ADDR_WIDTH-3:0] wb_adr_i,
    input  logic [3:0]            wb_sel_i,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic [ADDR_WIDTH-3:0] ram_a_o,
    output logic [31:0]           ram_wd_o,
    output logic [3:0]            ram_wen_o,
    input  logic [31:0]           ram_rd_i,
    output logic                  owner_o,
    output logic                  busy_o
);

    state_t     state_q;
    logic       owner_q;
    logic       cpu_q;
    logic [1:0] lane_q;
    logic       dp_ack_q;
    logic       wb_ack_q;
    logic       wb_err_q;
    logic       dp_rej_q;

    logic [3:0]  dp_wen;
    logic [31:0] dp_wd;
    logic [7:0]  dp_rbyte;

    logic wb_req;
    logic own_req;

    tpm_ram_lane_steer u_steer (
        .wr_lane (dp_addr_i[1:0]),
        .wr_byte (dp_data_i),
        .rd_lane (lane_q),
        .rd_word (ram_rd_i),
        .wen     (dp_wen),
        .wdata   (dp_wd),
        .rd_byte (dp_rbyte)
    );

    assign wb_req = wb_cyc_i & wb_stb_i;

    // Only serve when the owner register already agrees with exec_i, so a
    // pending ownership change is settled before the new owner is served.
    assign own_req = (owner_q == exec_i) &
                     ((owner_q == OWNER_CPU) ? wb_req : dp_req_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            owner_q   <= OWNER_DP;
            cpu_q     <= 1'b0;
            lane_q    <= 2'd0;
            ram_a_o   <= '0;
            ram_wd_o  <= '0;
            ram_wen_o <= '0;
            dp_ack_q  <= 1'b0;
            wb_ack_q  <= 1'b0;
        end else begin
            dp_ack_q <= 1'b0;
            wb_ack_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    owner_q <= exec_i;
                    if (own_req) begin
                        state_q <= ISSUE;
                        cpu_q   <= owner_q;
                        lane_q  <= dp_addr_i[1:0];
                        if (owner_q == OWNER_CPU) begin
                            ram_a_o   <= wb_adr_i;
                            ram_wd_o  <= wb_dat_i;
                            ram_wen_o <= wb_we_i ? wb_sel_i : 4'b0000;
                        end else begin
                            ram_a_o   <= dp_addr_i[ADDR_WIDTH-1:2];
                            ram_wd_o  <= dp_wd;
                            ram_wen_o <= dp_we_i ? dp_wen : 4'b0000;
                        end
                    end
                end
                ISSUE: begin
                    ram_wen_o <= 4'b0000;
                    state_q   <= WAIT;
                    if (cpu_q) wb_ack_q <= 1'b1;
                    else       dp_ack_q <= 1'b1;
                end
                WAIT: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    ram_wen_o <= 4'b0000;
                end
            endcase
        end
    end

    // Rejections bypass the FSM. A requester is rejected only when both
    // owner_q and exec_i say the other side owns the RAM; while they differ
    // the request simply waits for the ownership switch.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_err_q <= 1'b0;
            dp_rej_q <= 1'b0;
        end else begin
            wb_err_q <= wb_req & ~owner_q & ~exec_i & ~wb_err_q;
            dp_rej_q <= dp_req_i & owner_q & exec_i & ~dp_rej_q;
        end
    end

    // Read data arrives one cycle after the address, i.e. in the ack cycle,
    // so it is steered straight through rather than registered again.
    assign dp_ack_o  = dp_ack_q | dp_rej_q;
    assign dp_data_o = dp_rej_q ? DP_REJECT_DATA :
                       (dp_ack_q ? dp_rbyte : 8'h00);
    assign wb_ack_o  = wb_ack_q;
    assign wb_err_o  = wb_err_q;
    assign wb_dat_o  = wb_ack_q ? ram_rd_i : 32'h0;
    assign owner_o   = owner_q;
    assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_tpm_ram_arbiter.sv
// Scoreboard bench for tpm_ram_arbiter with a behavioural 512x32 RAM.
// Directed accesses push expected responses; a negedge monitor checks them.
module tb_tpm_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exec = 1'b0;
    logic        dp_req = 1'b0;
    logic        dp_we = 1'b0;
    logic [10:0] dp_addr = '0;
    logic [7:0]  dp_wdat = '0;
    logic [7:0]  dp_rdat;
    logic        dp_ack;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_we = 1'b0;
    logic [8:0]  wb_adr = '0;
    logic [3:0]  wb_sel = '0;
    logic [31:0] wb_wdat = '0;
    logic [31:0] wb_rdat;
    logic        wb_ack;
    logic        wb_err;
    logic [8:0]  ram_a;
    logic [31:0] ram_wd;
    logic [3:0]  ram_wen;
    logic [31:0] ram_rd = '0;
    logic        owner;
    logic        busy;

    logic [31:0] mem [512];

    typedef struct {
        int          kind;
        logic [31:0] data;
        bit          chk;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_wr = 0;

    tpm_ram_arbiter dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .exec_i    (exec),
        .dp_req_i  (dp_req),
        .dp_we_i   (dp_we),
        .dp_addr_i (dp_addr),
        .dp_data_i (dp_wdat),
        .dp_data_o (dp_rdat),
        .dp_ack_o  (dp_ack),
        .wb_cyc_i  (wb_cyc),
        .wb_stb_i  (wb_stb),
        .wb_we_i   (wb_we),
        .wb_adr_i  (wb_adr),
        .wb_sel_i  (wb_sel),
        .wb_dat_i  (wb_wdat),
        .wb_dat_o  (wb_rdat),
        .wb_ack_o  (wb_ack),
        .wb_err_o  (wb_err),
        .ram_a_o   (ram_a),
        .ram_wd_o  (ram_wd),
        .ram_wen_o (ram_wen),
        .ram_rd_i  (ram_rd),
        .owner_o   (owner),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'h1122_3344;
    end

    always @(posedge clk) begin
        ram_rd <= mem[ram_a];
        for (int b = 0; b < 4; b++)
            if (ram_wen[b]) mem[ram_a][8*b +: 8] <= ram_wd[8*b +: 8];
        if (ram_wen != 4'b0000) n_wr++;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] data,
                        input bit c);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.chk  = c;
        sbq.push_back(e);
    endtask

    task automatic mon_one(input int kind, input logic [31:0] data);
        exp_t e;
        if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_unexpected: got kind %0d data %h expected none",
                     kind, data);
        end else begin
            e = sbq.pop_front();
            chk("sb_kind", 32'(kind), 32'(e.kind));
            if (e.chk) chk("sb_data", data, e.data);
        end
    endtask

    // kind 0: dp ack, 1: wb ack, 2: wb err
    always @(negedge clk) begin
        if (!rst) begin
            if (dp_ack) mon_one(0, {24'd0, dp_rdat});
            if (wb_ack) mon_one(1, wb_rdat);
            if (wb_err) mon_one(2, 32'h0);
        end
    end

    task automatic access(input bit is_wb, input bit we,
                          input logic [10:0] addr, input logic [31:0] data,
                          input logic [3:0] sel, input int exp_lat,
                          input logic [3:0] exp_wen,
                          input logic [31:0] exp_wd,
                          input logic [8:0] exp_a);
        int          lat;
        logic [3:0]  wen1;
        logic [3:0]  wen2;
        logic [31:0] wd1;
        logic [8:0]  a1;
        logic        busy1;
        lat  = -1;
        wen1 = '0;
        wen2 = '0;
        wd1  = '0;
        a1   = '0;
        busy1 = 1'b0;
        @(posedge clk);
        #1;
        if (is_wb) begin
            wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
            wb_adr = addr[8:0]; wb_sel = sel; wb_wdat = data;
        end else begin
            dp_req = 1'b1; dp_we = we;
            dp_addr = addr; dp_wdat = data[7:0];
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 1) begin
                wen1 = ram_wen; wd1 = ram_wd; a1 = ram_a; busy1 = busy;
            end
            if (c == 2) wen2 = ram_wen;
            if (is_wb ? (wb_ack | wb_err) : dp_ack) begin
                lat = c;
                break;
            end
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; dp_req = 1'b0;
        if (lat < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout: got no response expected latency %0d",
                     exp_lat);
        end else begin
            chk("latency", 32'(lat), 32'(exp_lat));
            chk("ram_wen_issue", {28'd0, wen1}, {28'd0, exp_wen});
            if (exp_wen != 4'b0000) chk("ram_wd_issue", wd1, exp_wd);
            if (exp_lat == 2) begin
                chk("ram_a_issue", {23'd0, a1}, {23'd0, exp_a});
                chk("ram_wen_after", {28'd0, wen2}, 32'h0);
            end else begin
                chk("busy_reject", {31'd0, busy1}, 32'h0);
            end
        end
    endtask

    initial begin
        int  dpc;
        int  wbc;
        bit  own_at;
        repeat (2) @(negedge clk);
        chk("rst_acks", {29'd0, dp_ack, wb_ack, wb_err}, 32'h0);
        chk("rst_wen", {28'd0, ram_wen}, 32'h0);
        chk("rst_owner_busy", {30'd0, owner, busy}, 32'h0);
        chk("rst_addr", {23'd0, ram_a}, 32'h0);
        chk("rst_wd", ram_wd, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        push(0, 32'h0, 0);
        access(0, 1, 11'h006, 32'hA5, 4'h0, 2, 4'b0100, 32'h00A5_0000, 9'd1);
        push(0, 32'hA5, 1);
        access(0, 0, 11'h006, 32'h0, 4'h0, 2, 4'b0000, 32'h0, 9'd1);
        push(0, 32'h11, 1);
        access(0, 0, 11'h003, 32'h0, 4'h0, 2, 4'b0000, 32'h0, 9'd0);
        push(0, 32'h44, 1);
        access(0, 0, 11'h000, 32'h0, 4'h0, 2, 4'b0000, 32'h0, 9'd0);

        exec = 1'b1;
        repeat (2) @(negedge clk);
        chk("owner_cpu", {31'd0, owner}, 32'h1);

        push(1, 32'h0, 0);
        access(1, 1, 11'h1FF, 32'hDEAD_BEEF, 4'b0011, 2, 4'b0011,
               32'hDEAD_BEEF, 9'h1FF);
        push(1, 32'h1122_BEEF, 1);
        access(1, 0, 11'h1FF, 32'h0, 4'h0, 2, 4'b0000, 32'h0, 9'h1FF);
        push(1, 32'h0, 0);
        access(1, 1, 11'h1FF, 32'h0, 4'b0000, 2, 4'b0000, 32'h0, 9'h1FF);
        push(1, 32'h1122_BEEF, 1);
        access(1, 0, 11'h1FF, 32'h0, 4'h0, 2, 4'b0000, 32'h0, 9'h1FF);

        push(0, 32'hFF, 1);
        access(0, 1, 11'h004, 32'h77, 4'h0, 1, 4'b0000, 32'h0, 9'd0);
        push(1, 32'h11A5_3344, 1);
        access(1, 0, 11'h001, 32'h0, 4'h0, 2, 4'b0000, 32'h0, 9'd1);

        exec = 1'b0;
        repeat (2) @(negedge clk);
        chk("owner_dp", {31'd0, owner}, 32'h0);
        push(2, 32'h0, 0);
        access(1, 0, 11'h1FF, 32'h0, 4'h0, 1, 4'b0000, 32'h0, 9'd0);

        // ownership switch during a data-provider read
        @(posedge clk);
        #1;
        dp_req = 1'b1; dp_we = 1'b0; dp_addr = 11'h006;
        push(0, 32'hA5, 1);
        push(1, 32'h1122_BEEF, 1);
        @(posedge clk);
        #1;
        exec = 1'b1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 9'h1FF;
        dpc = -1;
        wbc = -1;
        own_at = 1'b0;
        for (int c = 1; c < 14; c++) begin
            @(negedge clk);
            if (dp_ack && dpc < 0) begin
                dpc = c;
                dp_req = 1'b0;
            end
            if (wb_ack && wbc < 0) begin
                wbc = c;
                own_at = owner;
                wb_cyc = 1'b0;
                wb_stb = 1'b0;
            end
            if (dpc >= 0 && wbc >= 0) break;
        end
        dp_req = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
        chk("switch_dp_cycle", 32'(dpc), 32'd2);
        chk("switch_wb_cycle", 32'(wbc), 32'd6);
        chk("switch_owner", {31'd0, own_at}, 32'h1);

        // reset while a write is in ISSUE
        @(posedge clk);
        #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
        wb_adr = 9'h010; wb_sel = 4'hF; wb_wdat = 32'hCAFE_F00D;
        @(negedge clk);
        @(negedge clk);
        chk("abort_wen_before", {28'd0, ram_wen}, 32'hF);
        #1 rst = 1'b1;
        #1;
        chk("abort_wen_now", {28'd0, ram_wen}, 32'h0);
        chk("abort_owner", {30'd0, owner, busy}, 32'h0);
        exec = 1'b0;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        push(0, 32'h44, 1);
        access(0, 0, 11'h040, 32'h0, 4'h0, 2, 4'b0000, 32'h0, 9'h010);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        chk("write_count", 32'(n_wr), 32'd2);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
